// File: rtl/vscale_src_b_merge_ctrl.sv
// Sequencer that produces the unmasked ALU operand B from rs2 shares, the immediate or the constant 4.
// Shares are XOR-folded one per cycle through a register. Optional macro: VSCALE_SRC_B_MERGE_CLEAR_EN.

`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`endif
`ifndef SRC_B_RS2
`define SRC_B_RS2 2'd0
`endif
`ifndef SRC_B_IMM
`define SRC_B_IMM 2'd1
`endif
`ifndef SRC_B_FOUR
`define SRC_B_FOUR 2'd2
`endif

module vscale_src_b_merge_ctrl #(
    parameter int DWIDTH = 32,
    parameter int SHARES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [`SRC_B_SEL_WIDTH-1:0]  src_b_sel,
    input  logic [DWIDTH-1:0]            imm,
    input  logic [SHARES*DWIDTH-1:0]     rs2_data_shares,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DWIDTH-1:0]            alu_src_b_merged,
    output logic                         busy
);

    localparam int IDX_W = (SHARES > 1) ? $clog2(SHARES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SHARES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DWIDTH-1:0]     acc_q, acc_d;
    logic [DWIDTH-1:0]     merged_q, merged_d;
    logic [DWIDTH-1:0]     shares_q [SHARES];
    logic [DWIDTH-1:0]     shares_d [SHARES];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        merged_d = merged_q;
        shares_d = shares_q;

        if (flush) begin
            // Flush wins over everything, including a same-cycle request or handshake.
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
`ifdef VSCALE_SRC_B_MERGE_CLEAR_EN
            merged_d = '0;
            for (int i = 0; i < SHARES; i++) shares_d[i] = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        for (int i = 0; i < SHARES; i++) begin
                            shares_d[i] = rs2_data_shares[i*DWIDTH +: DWIDTH];
                        end
                        state_d = DONE;
                        case (src_b_sel)
                            `SRC_B_RS2: begin
                                if (SHARES == 1) begin
                                    merged_d = rs2_data_shares[DWIDTH-1:0];
                                end else begin
                                    acc_d   = rs2_data_shares[DWIDTH-1:0];
                                    idx_d   = IDX_W'(1);
                                    state_d = ACCUM;
                                end
                            end
                            `SRC_B_IMM:  merged_d = imm;
                            `SRC_B_FOUR: merged_d = DWIDTH'(4);
                            default:     merged_d = '0;
                        endcase
                    end
                end
                ACCUM: begin
                    // The last share goes straight into the output register, never back into acc.
                    if (idx_q == LAST_IDX) begin
                        merged_d = acc_q ^ shares_q[idx_q];
                        acc_d    = '0;
                        idx_d    = '0;
                        state_d  = DONE;
                    end else begin
                        acc_d = acc_q ^ shares_q[idx_q];
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
`ifdef VSCALE_SRC_B_MERGE_CLEAR_EN
                        merged_d = '0;
                        for (int i = 0; i < SHARES; i++) shares_d[i] = '0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            merged_q <= '0;
            for (int i = 0; i < SHARES; i++) shares_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            merged_q <= merged_d;
            for (int i = 0; i < SHARES; i++) shares_q[i] <= shares_d[i];
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign out_valid        = (state_q == DONE);
    assign alu_src_b_merged = merged_q;

endmodule
